// File: rtl/issue_pkg.sv
// Shared definitions for the issue queues and the issue unit:
// integer funct codes, multiplier depth and the CDB broadcast record.
package issue_pkg;

  localparam int MULT_LAT_DEFAULT = 4;

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLTU = 6'h2B;

  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] data;
  } cdb_t;

endpackage

// File: rtl/issue_mult_pipe.sv
// Multiplier pipeline: operand register followed by a valid/tag/product delay
// line, presenting its result MULT_LAT-1 cycles after issue (the CDB register adds one).
module issue_mult_pipe
  import issue_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [5:0]  tag,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output cdb_t        result
);

  localparam int DEPTH = MULT_LAT - 1;

  logic [DEPTH-1:0] valid_r;
  logic [5:0]       tag_r [DEPTH];
  logic [31:0]      rs_r;
  logic [31:0]      rt_r;
  logic [31:0]      prod_s;
  logic [31:0]      prod_out_s;

  // Operand capture plus the valid/tag delay line; stage 0 is the operand register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      rs_r    <= 32'd0;
      rt_r    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= 6'd0;
      end
    end else begin
      valid_r[0] <= issue;
      tag_r[0]   <= tag;
      rs_r       <= rs_data;
      rt_r       <= rt_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        tag_r[i]   <= tag_r[i-1];
      end
    end
  end

  // The low word of a two's-complement product does not depend on operand signedness
  assign prod_s = rs_r * rt_r;

  if (DEPTH == 1) begin : g_no_prod_pipe
    assign prod_out_s = prod_s;
  end else begin : g_prod_pipe
    logic [31:0] prod_r [1:DEPTH-1];

    // Product delay line aligned with the valid/tag stages
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 1; i < DEPTH; i++) begin
          prod_r[i] <= 32'd0;
        end
      end else begin
        prod_r[1] <= prod_s;
        for (int i = 2; i < DEPTH; i++) begin
          prod_r[i] <= prod_r[i-1];
        end
      end
    end

    assign prod_out_s = prod_r[DEPTH-1];
  end

  assign result = {valid_r[DEPTH-1], tag_r[DEPTH-1], prod_out_s};

endmodule

// File: rtl/issue_unit.sv
// Issue unit: arbitrates between the integer and multiply queues, executes
// integer ops in one cycle, and drives a single registered CDB.
module issue_unit
  import issue_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issueint_ready,
  input  logic [5:0]  issueint_opcode,
  input  logic [5:0]  issueint_rdtag,
  input  logic [31:0] issueint_rsdata,
  input  logic [31:0] issueint_rtdata,
  output logic        issueint_done,
  input  logic        issuemul_ready,
  input  logic [5:0]  issuemul_rdtag,
  input  logic [31:0] issuemul_rsdata,
  input  logic [31:0] issuemul_rtdata,
  output logic        issuemul_done,
  output logic [5:0]  cdb_tag,
  output logic [31:0] cdb_data,
  output logic        cdb_valid
);

  // Bit i set: the CDB is owned by a multiply result i cycles from now
  logic [MULT_LAT-1:0] resv_r;
  logic                last_mul_r;
  logic                int_elig_s;
  logic                grant_int_s;
  logic                grant_mul_s;
  logic [31:0]         alu_s;
  cdb_t                mul_out_s;
  cdb_t                cdb_next_s;
  cdb_t                cdb_r;

  // Grant: integer needs next cycle's CDB slot free; ties go to the queue not served last
  always_comb begin
    int_elig_s  = issueint_ready & ~resv_r[1];
    grant_int_s = 1'b0;
    grant_mul_s = 1'b0;
    if (reset) begin
      grant_int_s = 1'b0;
      grant_mul_s = 1'b0;
    end else if (int_elig_s && issuemul_ready) begin
      grant_int_s = last_mul_r;
      grant_mul_s = ~last_mul_r;
    end else begin
      grant_int_s = int_elig_s;
      grant_mul_s = issuemul_ready;
    end
  end

  assign issueint_done = grant_int_s;
  assign issuemul_done = grant_mul_s;

  // Integer ALU; unknown funct codes still broadcast, with a zero result
  always_comb begin
    alu_s = 32'd0;
    case (issueint_opcode)
      OP_ADD:  alu_s = issueint_rsdata + issueint_rtdata;
      OP_SUB:  alu_s = issueint_rsdata - issueint_rtdata;
      OP_AND:  alu_s = issueint_rsdata & issueint_rtdata;
      OP_OR:   alu_s = issueint_rsdata | issueint_rtdata;
      OP_XOR:  alu_s = issueint_rsdata ^ issueint_rtdata;
      OP_NOR:  alu_s = ~(issueint_rsdata | issueint_rtdata);
      OP_SLT:  alu_s = ($signed(issueint_rsdata) < $signed(issueint_rtdata)) ? 32'd1 : 32'd0;
      OP_SLTU: alu_s = (issueint_rsdata < issueint_rtdata) ? 32'd1 : 32'd0;
      default: alu_s = 32'd0;
    endcase
  end

  issue_mult_pipe #(
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .issue   (grant_mul_s),
    .tag     (issuemul_rdtag),
    .rs_data (issuemul_rsdata),
    .rt_data (issuemul_rtdata),
    .result  (mul_out_s)
  );

  // Next CDB contents; the reservation keeps the two sources from ever coinciding
  always_comb begin
    cdb_next_s = {1'b0, 6'd0, 32'd0};
    if (grant_int_s) begin
      cdb_next_s = {1'b1, issueint_rdtag, alu_s};
    end else if (mul_out_s.valid) begin
      cdb_next_s = mul_out_s;
    end else begin
      cdb_next_s = {1'b0, 6'd0, 32'd0};
    end
  end

  // Reservation shift, priority memory and the CDB output register
  always_ff @(posedge clk) begin
    if (reset) begin
      resv_r     <= {MULT_LAT{1'b0}};
      last_mul_r <= 1'b1;
      cdb_r      <= {1'b0, 6'd0, 32'd0};
    end else begin
      resv_r <= {grant_mul_s, {(MULT_LAT-1){1'b0}}} | (resv_r >> 1'b1);
      if (grant_int_s || grant_mul_s) begin
        last_mul_r <= grant_mul_s;
      end else begin
        last_mul_r <= last_mul_r;
      end
      cdb_r <= cdb_next_s;
    end
  end

  assign cdb_valid = cdb_r.valid;
  assign cdb_tag   = cdb_r.tag;
  assign cdb_data  = cdb_r.data;

endmodule
